conv2_sched: RTL and testbench
==============================

Name: conv2_sched

Overview:
- Sequencer for the layer-2 convolution engine and its four row-SRAM banks.
- Accepts 16 pooled input rows from layer 1 over a valid/ready handshake and writes them to SRAM.
- Then runs one scan pass per output channel. Each pass requests that channel's filter load, reads the rows with top and bottom zero padding, and flags the valid output rows.
- Sits between the pooling stage and the conv/SRAM datapath; replaces ad-hoc address and enable generation.

Parameters:
- ROWS, 16, input rows per feature map (SRAM depth used).
- NUM_OC, 8, output-channel passes per feature map.
- PIPE_LAT, 4, cycles from sram_re to the matching output row at the conv engine output.
- ADDR_W, 10, SRAM address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset).
- start  in  1  begin a feature map; sampled only in IDLE.
- abort  in  1  cancel the current job; return to IDLE.
- row_valid  in  1  pooled row present on the datapath input.
- row_ready  out  1  scheduler accepts a row this cycle.
- sram_we  out  1  SRAM write strobe, all four banks.
- sram_re  out  1  SRAM read strobe.
- sram_addr  out  ADDR_W  SRAM address.
- feed_zero  out  1  conv input row must be zero (padding row).
- wt_load  out  1  one-cycle filter-load request.
- wt_ch  out  3  channel index for the filter load.
- out_valid  out  1  conv output row valid.
- out_row  out  4  output row index 0..ROWS-1.
- out_ch  out  3  channel of the current output row.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse after the last row of channel NUM_OC-1.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- All outputs are registered; a decision made in cycle N is visible in cycle N+1.
- FSM states: IDLE, FILL, WLOAD, SCAN, FIN.
- IDLE → FILL when start=1. A start outside IDLE is ignored.
- FILL:
  - row_ready=1.
  - Each cycle with row_valid&row_ready: next cycle sram_we=1, sram_addr=wr_ptr; wr_ptr increments.
  - When the ROWS-th row is accepted, row_ready drops in the same cycle's update. No further rows are accepted; row_valid is ignored.
  - Next state WLOAD with oc=0.
- WLOAD (1 cycle): wt_load=1, wt_ch=oc. Then SCAN with scan_cnt=0.
- SCAN: scan_cnt runs 0..PIPE_LAT+ROWS+1.
  - scan_cnt=0: sram_re=0, feed_zero=1 (top pad).
  - scan_cnt 1..ROWS: sram_re=1, sram_addr=scan_cnt-1, feed_zero=0.
  - scan_cnt=ROWS+1: sram_re=0, feed_zero=1 (bottom pad).
  - scan_cnt>ROWS+1: sram_re=0, feed_zero=1.
  - out_valid=1 when scan_cnt is in [PIPE_LAT+2, PIPE_LAT+ROWS+1].
  - out_row = scan_cnt-PIPE_LAT-2; out_ch=oc.
  - At the last scan_cnt: if oc<NUM_OC-1, oc++ and go to WLOAD; else go to FIN.
- FIN (1 cycle): done=1, busy=0 next, then IDLE.
- Per-channel cost: 1+PIPE_LAT+ROWS+2 cycles, which is 23 at defaults.
- abort:
  - Highest priority after reset, in any state.
  - Next cycle: IDLE, all strobes 0, no done, counters cleared.
  - SRAM contents are undefined for reuse afterwards.
- start and abort in the same cycle: abort wins.
- rst_n mid-job behaves like abort, and also clears outputs.
- sram_we and sram_re are never both 1.
- sram_addr holds its last value when neither strobe is active.

Optional Feature:
- Macro: CONV2_SCHED_REUSE_EN.
- When defined:
  - Adds input reuse (1 bit), sampled together with start.
  - start&reuse in IDLE skips FILL and goes directly to WLOAD, reusing the SRAM contents.
  - If no complete fill has occurred since reset or the last abort, reuse is ignored and the scheduler runs FILL.
- When undefined: the port is absent and every start runs FILL.

Test Plan:
1. Reset then idle: hold rst_n=1 for 2 cycles, release → all outputs 0, busy=0. Pulsing row_valid alone → no sram_we.
2. Full job at defaults: start, 16 back-to-back rows →
   - sram_we on addresses 0..15.
   - 8 wt_load pulses with wt_ch 0..7.
   - 128 out_valid cycles, out_row 0..15 within each channel.
   - done exactly 184 cycles after the WLOAD of channel 0 begins.
3. Stalled fill: rows given with row_valid gaps of 3 cycles → addresses stay contiguous 0..15, no write in gap cycles, row_ready=0 after the 16th row.
4. Padding check: within channel 3 → feed_zero=1 at scan_cnt 0 and 17; sram_re on addresses 0..15 only; first out_valid at scan_cnt 6, last at 21.
5. Abort mid-SCAN of channel 5, with start asserted in the same cycle → IDLE next cycle, no done, no further wt_load. A later start runs FILL.
6. With CONV2_SCHED_REUSE_EN:
   - After a complete job, start+reuse → first wt_load the cycle after FILL is skipped, no sram_we.
   - After an abort, start+reuse → FILL runs.

Source files
------------

// File: rtl/conv2_sched.sv
// conv2_sched: layer-2 conv sequencer (row fill, filter load, padded scan).
// Optional macro CONV2_SCHED_REUSE_EN adds the reuse input.
module conv2_sched #(
    parameter int ROWS     = 16,
    parameter int NUM_OC   = 8,
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef CONV2_SCHED_REUSE_EN
    input  logic              reuse,
`endif
    input  logic              abort,
    input  logic              row_valid,
    output logic              row_ready,
    output logic              sram_we,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              feed_zero,
    output logic              wt_load,
    output logic [2:0]        wt_ch,
    output logic              out_valid,
    output logic [3:0]        out_row,
    output logic [2:0]        out_ch,
    output logic              busy,
    output logic              done
);

    localparam int WW = $clog2(ROWS);
    localparam int SW = $clog2(PIPE_LAT + ROWS + 2);

    localparam logic [WW-1:0] WR_LAST = WW'(ROWS - 1);
    localparam logic [WW-1:0] WR_ONE  = WW'(1);
    localparam logic [SW-1:0] SC_LAST = SW'(PIPE_LAT + ROWS + 1);
    localparam logic [SW-1:0] SC_ROWS = SW'(ROWS);
    localparam logic [SW-1:0] SC_OV0  = SW'(PIPE_LAT + 2);
    localparam logic [SW-1:0] SC_ONE  = SW'(1);
    localparam logic [2:0]    OC_LAST = 3'(NUM_OC - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WLOAD,
        SCAN,
        FIN
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wr_ptr, wr_n;
    logic [SW-1:0] scan_cnt, scan_n;
    logic [2:0]    oc, oc_n;
    logic          filled, filled_n;
    logic          reuse_ok;

    logic              rdy_n, we_n, re_n, fz_n, wl_n;
    logic              ov_n, busy_n, done_n;
    logic [ADDR_W-1:0] addr_n;
    logic [2:0]        wch_n, och_n;
    logic [3:0]        orow_n;

`ifdef CONV2_SCHED_REUSE_EN
    assign reuse_ok = reuse & filled;
`else
    assign reuse_ok = 1'b0;
`endif

    // Next state, counters, and the output values they imply
    always_comb begin
        state_n  = state;
        wr_n     = wr_ptr;
        scan_n   = scan_cnt;
        oc_n     = oc;
        filled_n = filled;
        we_n     = 1'b0;
        addr_n   = sram_addr;

        if (abort) begin
            state_n  = IDLE;
            wr_n     = '0;
            scan_n   = '0;
            oc_n     = '0;
            filled_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        wr_n    = '0;
                        scan_n  = '0;
                        oc_n    = '0;
                        state_n = reuse_ok ? WLOAD : FILL;
                    end
                end
                FILL: begin
                    if (row_valid && row_ready) begin
                        we_n   = 1'b1;
                        addr_n = ADDR_W'(wr_ptr);
                        wr_n   = wr_ptr + WR_ONE;
                        if (wr_ptr == WR_LAST) begin
                            wr_n     = '0;
                            oc_n     = '0;
                            filled_n = 1'b1;
                            state_n  = WLOAD;
                        end
                    end
                end
                WLOAD: begin
                    scan_n  = '0;
                    state_n = SCAN;
                end
                SCAN: begin
                    if (scan_cnt == SC_LAST) begin
                        scan_n = '0;
                        if (oc == OC_LAST) begin
                            state_n = FIN;
                        end else begin
                            oc_n    = oc + 3'd1;
                            state_n = WLOAD;
                        end
                    end else begin
                        scan_n = scan_cnt + SC_ONE;
                    end
                end
                FIN: begin
                    oc_n    = '0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        rdy_n  = (state_n == FILL);
        wl_n   = (state_n == WLOAD);
        wch_n  = wl_n ? oc_n : wt_ch;
        re_n   = (state_n == SCAN) && (scan_n >= SC_ONE) &&
                 (scan_n <= SC_ROWS);
        fz_n   = (state_n == SCAN) && !re_n;
        ov_n   = (state_n == SCAN) && (scan_n >= SC_OV0);
        orow_n = ov_n ? 4'(scan_n - SC_OV0) : 4'd0;
        och_n  = ov_n ? oc_n : 3'd0;
        busy_n = (state_n != IDLE);
        done_n = (state_n == FIN);
        if (re_n) begin
            addr_n = ADDR_W'(scan_n - SC_ONE);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            scan_cnt  <= '0;
            oc        <= '0;
            filled    <= 1'b0;
            row_ready <= 1'b0;
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            sram_addr <= '0;
            feed_zero <= 1'b0;
            wt_load   <= 1'b0;
            wt_ch     <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_n;
            scan_cnt  <= scan_n;
            oc        <= oc_n;
            filled    <= filled_n;
            row_ready <= rdy_n;
            sram_we   <= we_n;
            sram_re   <= re_n;
            sram_addr <= addr_n;
            feed_zero <= fz_n;
            wt_load   <= wl_n;
            wt_ch     <= wch_n;
            out_valid <= ov_n;
            out_row   <= orow_n;
            out_ch    <= och_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: scoreboard bench for conv2_sched.
// Reuse checks run only when CONV2_SCHED_REUSE_EN is defined.
module tb_conv2_sched;

    localparam int ROWS     = 16;
    localparam int NUM_OC   = 8;
    localparam int PIPE_LAT = 4;
    localparam int ADDR_W   = 10;
    localparam int SC_N     = PIPE_LAT + ROWS + 2;
    localparam int CH_CYC   = 1 + SC_N;

    localparam int QW = 0;
    localparam int QL = 1;
    localparam int QR = 2;
    localparam int QO = 3;
    localparam int QF = 4;
    localparam int QD = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              row_valid;
    logic              row_ready;
    logic              sram_we;
    logic              sram_re;
    logic [ADDR_W-1:0] sram_addr;
    logic              feed_zero;
    logic              wt_load;
    logic [2:0]        wt_ch;
    logic              out_valid;
    logic [3:0]        out_row;
    logic [2:0]        out_ch;
    logic              busy;
    logic              done;
`ifdef CONV2_SCHED_REUSE_EN
    logic              reuse;
`endif

    conv2_sched #(
        .ROWS    (ROWS),
        .NUM_OC  (NUM_OC),
        .PIPE_LAT(PIPE_LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef CONV2_SCHED_REUSE_EN
        .reuse    (reuse),
`endif
        .abort    (abort),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .sram_we  (sram_we),
        .sram_re  (sram_re),
        .sram_addr(sram_addr),
        .feed_zero(feed_zero),
        .wt_load  (wt_load),
        .wt_ch    (wt_ch),
        .out_valid(out_valid),
        .out_row  (out_row),
        .out_ch   (out_ch),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q[6][$];
    int  errs   = 0;
    int  checks = 0;
    bit  filled_m = 1'b0;

    function automatic string qname(int k);
        case (k)
            QW:      return "sram_write";
            QL:      return "wt_load";
            QR:      return "sram_read";
            QO:      return "out_row";
            QF:      return "feed_zero";
            default: return "done";
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(int k, int c, int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q[k].push_back(e);
    endtask

    task automatic mon(int k, logic act, int val);
        ev_t e;
        if (!act) return;
        checks++;
        if (q[k].size() == 0) begin
            errs++;
            $display("FAIL %s: unexpected at cycle %0d val %0d, required none",
                     qname(k), cyc, val);
        end else begin
            e = q[k].pop_front();
            if (e.cyc != cyc || e.val != val) begin
                errs++;
                $display("FAIL %s: got cycle %0d val %0d, required cycle %0d val %0d",
                         qname(k), cyc, val, e.cyc, e.val);
            end
        end
    endtask

    task automatic drain_chk(string tag);
        for (int k = 0; k < 6; k++) begin
            chk({tag, "_", qname(k), "_left"}, q[k].size(), 0);
        end
    endtask

    task automatic prune(int a);
        ev_t d;
        for (int k = 0; k < 6; k++) begin
            while (q[k].size() > 0 && q[k][q[k].size() - 1].cyc > a) begin
                d = q[k].pop_back();
            end
        end
    endtask

    // Expected job timeline derived from the scan rules: channel j loads
    // its filter at L+1+23j and scans scan_cnt 0..21 in the next cycles.
    task automatic push_sched(int L);
        int w;
        int c;
        for (int j = 0; j < NUM_OC; j++) begin
            w = L + 1 + CH_CYC * j;
            push(QL, w, j);
            for (int k = 0; k < SC_N; k++) begin
                c = w + 1 + k;
                if (k >= 1 && k <= ROWS) push(QR, c, k - 1);
                else push(QF, c, 0);
                if (k >= PIPE_LAT + 2) push(QO, c, j * 16 + (k - PIPE_LAT - 2));
            end
        end
        push(QD, L + 1 + CH_CYC * NUM_OC, 1);
    endtask

    // Monitor: every output strobe is matched against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mon(QW, sram_we, int'(sram_addr));
            mon(QL, wt_load, int'(wt_ch));
            mon(QR, sram_re, int'(sram_addr));
            mon(QO, out_valid, int'(out_ch) * 16 + int'(out_row));
            mon(QF, feed_zero, 0);
            mon(QD, done, 1);
            if (sram_we || sram_re) chk("we_re_exclusive", int'(sram_we & sram_re), 0);
        end
    end

    task automatic run_fill(int gap, output int L);
        int acc;
        int g;
        acc = 0;
        L = cyc;
        while (acc < ROWS) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            row_valid = 1'b0;
            repeat (g) tick();
            row_valid = 1'b1;
            chk("fill_row_ready", int'(row_ready), 1);
            push(QW, cyc + 1, acc);
            acc++;
            L = cyc;
            tick();
        end
        chk("fill_ready_drop", int'(row_ready), 0);
        filled_m = 1'b1;
    endtask

    task automatic begin_job(int gap, bit ru, output int L);
        int  s;
        bit  use_reuse;
        use_reuse = ru && filled_m;
        start = 1'b1;
`ifdef CONV2_SCHED_REUSE_EN
        reuse = ru;
`endif
        s = cyc;
        tick();
        start = 1'b0;
`ifdef CONV2_SCHED_REUSE_EN
        reuse = 1'b0;
`endif
        chk("busy_after_start", int'(busy), 1);
        if (use_reuse) begin
            L = s;
            push_sched(L);
        end else begin
            run_fill(gap, L);
            push_sched(L);
            tick();
            tick();
            row_valid = 1'b0;
        end
    endtask

    task automatic finish_job(string tag, int L);
        int lim;
        lim = 0;
        while (cyc < L + 2 + CH_CYC * NUM_OC && lim < 400) begin
            tick();
            lim++;
        end
        chk({tag, "_busy_end"}, int'(busy), 0);
        chk({tag, "_done_end"}, int'(done), 0);
        drain_chk(tag);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int L;
        int a;
        int k;

        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        row_valid = 1'b0;
`ifdef CONV2_SCHED_REUSE_EN
        reuse     = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b0;
        chk("rst_row_ready", int'(row_ready), 0);
        chk("rst_sram_we", int'(sram_we), 0);
        chk("rst_sram_re", int'(sram_re), 0);
        chk("rst_sram_addr", int'(sram_addr), 0);
        chk("rst_feed_zero", int'(feed_zero), 0);
        chk("rst_wt_load", int'(wt_load), 0);
        chk("rst_wt_ch", int'(wt_ch), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        row_valid = 1'b1;
        repeat (4) tick();
        row_valid = 1'b0;
        tick();
        chk("idle_row_ready", int'(row_ready), 0);
        chk("idle_busy", int'(busy), 0);
        drain_chk("idle");

        repeat ($urandom_range(1, 4)) tick();
        begin_job(0, 1'b0, L);
        finish_job("job_b2b", L);

        repeat ($urandom_range(1, 4)) tick();
        begin_job(3, 1'b0, L);
        finish_job("job_gap3", L);

        repeat ($urandom_range(1, 4)) tick();
        begin_job(-1, 1'b0, L);
        finish_job("job_rand", L);

`ifdef CONV2_SCHED_REUSE_EN
        repeat ($urandom_range(1, 4)) tick();
        begin_job(-1, 1'b1, L);
        finish_job("job_reuse", L);
`endif

        repeat ($urandom_range(1, 4)) tick();
        begin_job(-1, 1'b0, L);
        k = int'($urandom_range(0, SC_N - 1));
        a = L + 1 + CH_CYC * 5 + 1 + k;
        while (cyc < a) tick();
        abort = 1'b1;
        start = 1'b1;
        prune(a);
        tick();
        abort = 1'b0;
        start = 1'b0;
        filled_m = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sram_re", int'(sram_re), 0);
        chk("abort_feed_zero", int'(feed_zero), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        repeat (40) tick();
        chk("abort_stays_idle", int'(busy), 0);
        drain_chk("abort");

`ifdef CONV2_SCHED_REUSE_EN
        begin_job(-1, 1'b1, L);
`else
        begin_job(-1, 1'b0, L);
`endif
        finish_job("job_after_abort", L);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
